// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// overlap mode encodings, fill-counter width helper, saturating increment.
package seq_det_pkg;

    // cfg_overlap encodings
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Width needed to count 0..len-1 valid history bits (at least one bit)
    function automatic int fill_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Increment that sticks at max instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, clr zeroes it.
module seq_det_sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise saturating increment on inc
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector built as a shift register plus
// comparator, so any pattern (including self-overlapping ones) is exact.
// Optional macro SEQ_DET_MASK_EN adds cfg_mask: set bits are don't-care.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PATTERN_LEN = 3,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in,
    input  logic                   data_valid,
    input  logic                   clear,
    input  logic [PATTERN_LEN-1:0] cfg_pattern,
    input  logic                   cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [PATTERN_LEN-1:0] cfg_mask,
`endif
    output logic                   seq_detected,
    output logic [CNT_W-1:0]       match_count
);

    localparam int               FILL_W   = fill_w(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

    logic [PATTERN_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [PATTERN_LEN-1:0] window;
    logic                   pat_hit;

    // Oldest history bit lines up with the pattern MSB (first bit received)
    assign window = {hist_q, data_in};

`ifdef SEQ_DET_MASK_EN
    assign pat_hit = ((window ^ cfg_pattern) & ~cfg_mask) == '0;
`else
    assign pat_hit = (window == cfg_pattern);
`endif

    // Zero-latency detect; needs a full history and an accepted, uncleared bit
    assign seq_detected = data_valid & ~clear & (fill_q == FILL_MAX) & pat_hit;

    // Next history/fill: clear first, then shift on accepted bits
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (data_valid) begin
            // Shift left, new bit in LSB; after a non-overlapping match the
            // history content is irrelevant because fill restarts at zero
            hist_d = window[PATTERN_LEN-2:0];
            if (seq_detected) begin
                case (cfg_overlap)
                    MODE_OVL:    fill_d = FILL_MAX;
                    MODE_NONOVL: fill_d = '0;
                    default:     fill_d = '0;
                endcase
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // History and fill registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (seq_detected),
        .clr   (clear),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (3-bit pattern with a 2-bit
// counter, 4-bit pattern with an 8-bit counter) share one input stream and
// are checked every cycle against a queue-based reference model, plus
// directed literal expectations.
module tb_seq_detector_param;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       data_in     = 1'b0;
    logic       data_valid  = 1'b0;
    logic       clear       = 1'b0;
    logic       cfg_overlap = 1'b0;
    logic [2:0] pat3        = 3'b101;
    logic [2:0] mask3       = 3'b000;
    logic [3:0] pat4        = 4'b1101;
    logic [3:0] mask4       = 4'b0000;

    logic       det3, det4;
    logic [1:0] cnt3;
    logic [7:0] cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model: bits accepted since the last restart point, and counts
    bit q3[$];
    bit q4[$];
    int c3 = 0;
    int c4 = 0;

    logic [15:0] dh3, dh4;   // detect history of valid steps, first bit in MSB
    logic        gap_det;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_LEN(3), .CNT_W(2)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .clear        (clear),
        .cfg_pattern  (pat3),
        .cfg_overlap  (cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask     (mask3),
`endif
        .seq_detected (det3),
        .match_count  (cnt3)
    );

    seq_detector_param #(.PATTERN_LEN(4), .CNT_W(8)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .clear        (clear),
        .cfg_pattern  (pat4),
        .cfg_overlap  (cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask     (mask4),
`endif
        .seq_detected (det4),
        .match_count  (cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Do the last len bits of (accepted bits + din) equal the pattern?
    function automatic logic pred(input bit q[$], input int len, input logic [31:0] pat,
                                  input logic [31:0] msk, input logic din);
        bit w[$];
        w = q;
        w.push_back(din);
        if (w.size() < len) return 1'b0;
        for (int i = 0; i < len; i++) begin
            int pi = len - 1 - i;
            if (!msk[pi] && (w[w.size() - len + i] != pat[pi])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_d3();
        return !reset && data_valid && !clear && pred(q3, 3, 32'(pat3), 32'(mask3), data_in);
    endfunction

    function automatic logic exp_d4();
        return !reset && data_valid && !clear && pred(q4, 4, 32'(pat4), 32'(mask4), data_in);
    endfunction

    // Model update
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q3.delete();
            q4.delete();
            c3 <= 0;
            c4 <= 0;
        end else if (clear) begin
            q3.delete();
            q4.delete();
            c3 <= 0;
            c4 <= 0;
        end else if (data_valid) begin
            if (exp_d3()) c3 <= (c3 < 3) ? c3 + 1 : 3;
            if (exp_d3() && !cfg_overlap) q3.delete();
            else begin
                q3.push_back(data_in);
                if (q3.size() > 2) void'(q3.pop_front());
            end
            if (exp_d4()) c4 <= (c4 < 255) ? c4 + 1 : 255;
            if (exp_d4() && !cfg_overlap) q4.delete();
            else begin
                q4.push_back(data_in);
                if (q4.size() > 3) void'(q4.pop_front());
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("det3_model", 32'(det3), 32'(exp_d3()));
        check("det4_model", 32'(det4), 32'(exp_d4()));
        check("cnt3_model", 32'(cnt3), 32'(c3));
        check("cnt4_model", 32'(cnt4), 32'(c4));
    end

    task automatic step(input logic v, input logic b, input logic clr);
        data_valid = v;
        data_in    = b;
        clear      = clr;
        @(negedge clk);
        #1;
        if (v) begin
            dh3 = {dh3[14:0], det3};
            dh4 = {dh4[14:0], det4};
        end else begin
            gap_det = gap_det | det3 | det4;
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic restart(input logic ovl);
        cfg_overlap = ovl;
        step(1'b0, 1'b0, 1'b1);
        dh3     = '0;
        dh4     = '0;
        gap_det = 1'b0;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0);
    endtask

    initial begin
        dh3 = '0;
        dh4 = '0;
        gap_det = 1'b0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_det3", 32'(det3), 32'd0);
        check("reset_cnt3", 32'(cnt3), 32'd0);
        check("reset_cnt4", 32'(cnt4), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 101, non-overlapping, stream 10101
        restart(1'b0);
        send(16'b10101, 5);
        check("t1_det3", 32'(dh3[4:0]), 32'h04);
        check("t1_cnt3", 32'(cnt3), 32'd1);

        // 101, overlapping
        restart(1'b1);
        send(16'b10101, 5);
        check("t2_det3", 32'(dh3[4:0]), 32'h05);
        check("t2_cnt3", 32'(cnt3), 32'd2);

        // 1101 on the 4-bit instance, both modes
        restart(1'b1);
        send(16'b1101101, 7);
        check("t3_ovl_det4", 32'(dh4[6:0]), 32'h09);
        check("t3_ovl_cnt4", 32'(cnt4), 32'd2);
        restart(1'b0);
        send(16'b1101101, 7);
        check("t3_nov_det4", 32'(dh4[6:0]), 32'h08);

        // Gaps of data_valid=0 inside a pattern
        restart(1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t4_det3", 32'(dh3[2:0]), 32'h1);
        check("t4_gap", 32'(gap_det), 32'd0);
        check("t4_cnt3", 32'(cnt3), 32'd1);

        // Counter saturation, then clear with a matching window presented
        restart(1'b1);
        send(16'b10101010101, 11);
        check("t5_det3", 32'(dh3[10:0]), 32'h155);
        check("t5_sat", 32'(cnt3), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("t5_clr_det", 32'(dh3[0]), 32'd0);
        check("t5_clr_cnt", 32'(cnt3), 32'd0);

        // Reset in the middle of a sequence
        restart(1'b0);
        send(16'b10, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dh3 = '0;
        step(1'b1, 1'b1, 1'b0);
        check("t6_no_det", 32'(dh3[0]), 32'd0);
        send(16'b01, 2);
        check("t6_det3", 32'(dh3[2:0]), 32'h1);

`ifdef SEQ_DET_MASK_EN
        // Masked middle bit
        mask3 = 3'b010;
        restart(1'b0);
        send(16'b111, 3);
        check("t7_mask_det3", 32'(dh3[2:0]), 32'h1);
        mask3 = 3'b000;
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
